// File: rtl/link_pkg.sv
// Shared types and encodings for the board-to-board character link.
// Used by both the transmitter and the receiver.
package link_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  function automatic logic parity_bit(
    input logic [7:0] b,
    input int         mode
  );
    return (mode == PARITY_ODD) ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/char_serial_tx_if.sv
// PIO-side handshake bundle of the character transmitter.
// master = firmware side, slave = transmitter.
interface char_serial_tx_if;

  logic [7:0] data_out;
  logic       load;
  logic       trans_en;
  logic       tx;
  logic       char_sent;
  logic       busy;
  logic       hold_full;

  modport master (
    output data_out, load, trans_en,
    input  tx, char_sent, busy, hold_full
  );

  modport slave (
    input  data_out, load, trans_en,
    output tx, char_sent, busy, hold_full
  );

endinterface

// File: rtl/char_serial_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on terminal count.
// Shared with the receiver.
module bit_timer
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/char_serial_tx.sv
// Character link transmitter: start / 8 data LSB-first / opt parity / stop.
// Single holding register in front of the shift register.
module char_serial_tx
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input logic             clk,
  input logic             reset,
  char_serial_tx_if.slave bus
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e  state, state_n;
  logic       load_q, load_rise;
  logic       tick, tmr_clr;
  logic       start, shift, done, done_q;
  logic       tx_d;
  logic [7:0] hold_reg, shift_reg;
  logic [2:0] bit_idx;
  logic       par_q;
  logic       tx_q, busy_q, sent_q, hold_full;

  assign load_rise = bus.load & ~load_q;
  assign tmr_clr   = (state_n != state);

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.char_sent = sent_q;
  assign bus.hold_full = hold_full;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(tmr_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    tx_d    = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (hold_full && bus.trans_en) begin
          state_n = S_START;
          start   = 1'b1;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) state_n = S_DATA;
      end
      S_DATA: begin
        tx_d = shift_reg[0];
        if (tick) begin
          shift = 1'b1;
          if (bit_idx == 3'd7)
            state_n = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (tick) state_n = S_STOP;
      end
      S_STOP: begin
        if (tick && bit_idx == LAST_STOP) begin
          // a pending byte chains straight into its start bit
          if (hold_full && bus.trans_en) begin
            state_n = S_START;
            start   = 1'b1;
          end else begin
            state_n = S_IDLE;
            done    = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_q    <= 1'b0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      par_q     <= 1'b0;
      bit_idx   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      load_q    <= bus.load;
      tx_q      <= tx_d;
      busy_q    <= (state != S_IDLE);
      // line lags state by one cycle; done_q keeps char_sent behind the stop bit
      done_q    <= done & ~load_rise;
      hold_full <= load_rise | (hold_full & ~start);
      if (load_rise) hold_reg <= bus.data_out;
      if (start) begin
        shift_reg <= hold_reg;
        par_q     <= parity_bit(hold_reg, PARITY);
      end else if (shift) begin
        shift_reg <= shift_reg >> 1;
      end
      if (tmr_clr)
        bit_idx <= '0;
      else if (tick && (state == S_DATA || state == S_STOP))
        bit_idx <= bit_idx + 1'b1;
      if (load_rise)   sent_q <= 1'b0;
      else if (done_q) sent_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_char_serial_tx.sv
// Directed bench for char_serial_tx at CLKS_PER_BIT=4.
// Three instances cover no / even / odd parity.
module tb_char_serial_tx;

  localparam int CPB = 4;

  logic clk;
  logic reset;

  char_serial_tx_if bus0 ();
  char_serial_tx_if bus1 ();
  char_serial_tx_if bus2 ();

  assign bus1.data_out = bus0.data_out;
  assign bus1.load     = bus0.load;
  assign bus1.trans_en = bus0.trans_en;
  assign bus2.data_out = bus0.data_out;
  assign bus2.load     = bus0.load;
  assign bus2.trans_en = bus0.trans_en;

  char_serial_tx #(
    .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  char_serial_tx #(
    .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  char_serial_tx #(
    .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests;
  int   n_fail;
  logic cs_seen;

  logic [44:0] t0, t1, t2, c0, c1, c2, b0;
  logic [31:0] f0, f1, f2;
  logic        acc_tx, acc_busy, acc_cs;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(
    input string       tag,
    input int          nbits,
    input logic [31:0] frame,
    input int          ia,
    input logic [7:0]  ba,
    input int          ib,
    input logic [7:0]  bb
  );
    for (int b = 0; b < nbits; b++) begin
      logic [3:0] s;
      for (int c = 0; c < CPB; c++) begin
        int k;
        k = b * CPB + c;
        s[c] = bus0.tx;
        cs_seen = cs_seen | bus0.char_sent;
        if (k == ia + 1 || k == ib + 1) bus0.load = 1'b0;
        if (k == ia) begin
          bus0.data_out = ba;
          bus0.load     = 1'b1;
        end
        if (k == ib) begin
          bus0.data_out = bb;
          bus0.load     = 1'b1;
        end
        step();
      end
      check($sformatf("%s_bit%0d", tag, b),
            32'(s), 32'({4{frame[b]}}));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cs_seen = 1'b0;
    reset         = 1'b1;
    bus0.data_out = 8'h00;
    bus0.load     = 1'b0;
    bus0.trans_en = 1'b0;
    step();
    step();
    check("rst_tx",   32'(bus0.tx),        32'd1);
    check("rst_sent", 32'(bus0.char_sent), 32'd0);
    check("rst_busy", 32'(bus0.busy),      32'd0);
    check("rst_hold", 32'(bus0.hold_full), 32'd0);

    // frame 0xA5 on all three parity modes
    reset         = 1'b0;
    bus0.trans_en = 1'b1;
    bus0.data_out = 8'hA5;
    bus0.load     = 1'b1;
    step();
    bus0.load = 1'b0;
    check("lat_hold", 32'(bus0.hold_full), 32'd1);
    step();
    check("lat_e1_tx", 32'(bus0.tx), 32'd1);
    step();
    for (int i = 0; i < 45; i++) begin
      t0[i] = bus0.tx;
      t1[i] = bus1.tx;
      t2[i] = bus2.tx;
      c0[i] = bus0.char_sent;
      c1[i] = bus1.char_sent;
      c2[i] = bus2.char_sent;
      b0[i] = bus0.busy;
      step();
    end
    f0 = {21'h0, 1'b1, 1'b1, 8'hA5, 1'b0};
    f1 = {21'h0, 1'b1, 1'b0, 8'hA5, 1'b0};
    f2 = {21'h0, 1'b1, 1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 11; b++) begin
      check($sformatf("p0_bit%0d", b),
            32'(t0[b*CPB +: CPB]), 32'({4{f0[b]}}));
      check($sformatf("pe_bit%0d", b),
            32'(t1[b*CPB +: CPB]), 32'({4{f1[b]}}));
      check($sformatf("po_bit%0d", b),
            32'(t2[b*CPB +: CPB]), 32'({4{f2[b]}}));
    end
    check("p0_sent39", 32'(c0[39]), 32'd0);
    check("p0_sent40", 32'(c0[40]), 32'd1);
    check("p0_busy39", 32'(b0[39]), 32'd1);
    check("p0_busy40", 32'(b0[40]), 32'd0);
    check("pe_sent43", 32'(c1[43]), 32'd0);
    check("pe_sent44", 32'(c1[44]), 32'd1);
    check("po_sent43", 32'(c2[43]), 32'd0);
    check("po_sent44", 32'(c2[44]), 32'd1);
    check("pe_hold", 32'(bus1.hold_full), 32'd0);
    check("po_busy", 32'(bus2.busy),      32'd0);

    // back-to-back 0x11 then 0x22
    bus0.data_out = 8'h11;
    bus0.load     = 1'b1;
    step();
    bus0.load = 1'b0;
    check("b2b_sent_clr", 32'(bus0.char_sent), 32'd0);
    step();
    step();
    cs_seen = 1'b0;
    watch("b2b", 20,
          {12'h0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0},
          0, 8'h22, -1, 8'h00);
    check("b2b_no_early_sent", 32'(cs_seen),        32'd0);
    check("b2b_sent_end",      32'(bus0.char_sent), 32'd1);
    check("b2b_busy_end",      32'(bus0.busy),      32'd0);

    // trans_en gating
    bus0.trans_en = 1'b0;
    bus0.data_out = 8'h3C;
    bus0.load     = 1'b1;
    step();
    bus0.load = 1'b0;
    check("gate_hold", 32'(bus0.hold_full), 32'd1);
    check("gate_sent", 32'(bus0.char_sent), 32'd0);
    acc_tx   = 1'b1;
    acc_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      acc_tx   = acc_tx & bus0.tx;
      acc_busy = acc_busy | bus0.busy;
      step();
    end
    check("gate_tx_idle", 32'(acc_tx),   32'd1);
    check("gate_no_busy", 32'(acc_busy), 32'd0);
    bus0.trans_en = 1'b1;
    step();
    check("gate_e1_tx",   32'(bus0.tx),        32'd1);
    check("gate_e1_hold", 32'(bus0.hold_full), 32'd0);
    step();
    watch("gate", 10, {22'h0, 1'b1, 8'h3C, 1'b0}, -1, 8'h00, -1, 8'h00);
    check("gate_sent_end", 32'(bus0.char_sent), 32'd1);

    // reset during data bit 3
    bus0.data_out = 8'h00;
    bus0.load     = 1'b1;
    step();
    bus0.load = 1'b0;
    step();
    step();
    for (int k = 0; k < 17; k++) begin
      if (k == 5) begin
        bus0.data_out = 8'h01;
        bus0.load     = 1'b1;
      end
      if (k == 6) bus0.load = 1'b0;
      step();
    end
    check("rmid_tx_pre",   32'(bus0.tx),        32'd0);
    check("rmid_hold_pre", 32'(bus0.hold_full), 32'd1);
    reset = 1'b1;
    step();
    check("rmid_tx",   32'(bus0.tx),        32'd1);
    check("rmid_busy", 32'(bus0.busy),      32'd0);
    check("rmid_hold", 32'(bus0.hold_full), 32'd0);
    check("rmid_sent", 32'(bus0.char_sent), 32'd0);
    reset  = 1'b0;
    acc_tx = 1'b1;
    acc_cs = 1'b0;
    for (int i = 0; i < 48; i++) begin
      acc_tx = acc_tx & bus0.tx;
      acc_cs = acc_cs | bus0.char_sent;
      step();
    end
    check("rmid_quiet_tx",   32'(acc_tx), 32'd1);
    check("rmid_quiet_sent", 32'(acc_cs), 32'd0);

    // last write wins in the holding register
    bus0.data_out = 8'h00;
    bus0.load     = 1'b1;
    step();
    bus0.load = 1'b0;
    step();
    step();
    cs_seen = 1'b0;
    watch("drop", 20,
          {12'h0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h00, 1'b0},
          2, 8'h01, 6, 8'h02);
    check("drop_no_early_sent", 32'(cs_seen),        32'd0);
    check("drop_sent_end",      32'(bus0.char_sent), 32'd1);
    check("drop_hold_end",      32'(bus0.hold_full), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
